srl_fifo: RTL

Synchronous FIFO that buffers a WIDTH-bit stream in SRLC32E shift-register storage and drains it through a registered output stage. The write side shifts words into the SRLs. This block is the read end: it tracks occupancy and addresses the oldest word through the SRL tap address. It sits between streaming producers and consumers as a LUT-cheap elastic buffer (32 SRL entries + 1 output register = 33 words).

---
 rtl/srl_pkg.sv | 16 +
 rtl/srl_fifo_srl.sv | 27 ++
 rtl/srl_fifo.sv | 110 +++++++++++
 3 files changed

// File: rtl/srl_pkg.sv
// rtl/srl_pkg.sv - shared constants and state type for the SRL-backed FIFO
package srl_pkg;

    localparam int SRL_DEPTH  = 32;
    localparam int SRL_AW     = 5;
    localparam int LEVEL_W    = 6;
    localparam int FIFO_DEPTH = SRL_DEPTH + 1;

    // EMPTY: nothing held; OUT: only the output register; RUN: SRL also holds words
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_OUT   = 2'd1,
        ST_RUN   = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/srl_fifo_srl.sv
// rtl/srl_fifo_srl.sv - WIDTH-wide array of 32-deep addressable shift registers (SRLC32E style)
module srl_fifo_srl
    import srl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              i_clk,
    input  logic              i_ce,
    input  logic [SRL_AW-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_data,
    output logic [WIDTH-1:0]  o_data
);

    // Stage 0 holds the newest word; the tap at address n returns the word pushed n shifts ago.
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        logic [SRL_DEPTH-1:0] r_sr;

        always_ff @(posedge i_clk) begin
            if (i_ce) begin
                r_sr <= {r_sr[SRL_DEPTH-2:0], i_data[g]};
            end
        end

        assign o_data[g] = r_sr[i_addr];
    end

endmodule

// File: rtl/srl_fifo.sv
// rtl/srl_fifo.sv - 33-word elastic FIFO: SRL storage plus a registered output stage
module srl_fifo
    import srl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int AFULL_LEVEL = 28
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [WIDTH-1:0]   S_DATA,
    input  logic               S_VALID,
    output logic               S_READY,
    output logic [WIDTH-1:0]   M_DATA,
    output logic               M_VALID,
    input  logic               M_READY,
    output logic [LEVEL_W-1:0] LEVEL,
    output logic               AFULL
);

    localparam logic [LEVEL_W-1:0] CNT_FULL  = LEVEL_W'(SRL_DEPTH);
    localparam logic [LEVEL_W-1:0] AFULL_THR = LEVEL_W'(AFULL_LEVEL);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(FIFO_DEPTH);

    fifo_state_t        r_state;
    fifo_state_t        w_state_next;
    logic [LEVEL_W-1:0] r_cnt;
    logic [LEVEL_W-1:0] w_cnt_next;
    logic [WIDTH-1:0]   r_m_data;
    logic [WIDTH-1:0]   w_tap;
    logic [SRL_AW-1:0]  w_addr;
    logic               w_m_valid;
    logic               w_cnt_zero;
    logic               w_push;
    logic               w_load_out;
    logic               w_bypass;
    logic               w_srl_push;
    logic               w_srl_pop;
    logic [LEVEL_W-1:0] w_level;

    assign w_m_valid  = (r_state != ST_EMPTY);
    assign w_cnt_zero = (r_cnt == '0);

    // Ready looks only at the SRL count, so a full FIFO refuses a word even while draining.
    assign S_READY    = RST_N & (r_cnt != CNT_FULL);
    assign w_push     = S_VALID & S_READY;
    assign w_load_out = (~w_m_valid | M_READY) & (~w_cnt_zero | w_push);
    assign w_bypass   = w_load_out & w_cnt_zero & w_push;
    assign w_srl_push = w_push & ~w_bypass;
    assign w_srl_pop  = w_load_out & ~w_cnt_zero;

    // Oldest word sits at cnt-1; the tap is read before this edge's shift.
    assign w_addr     = SRL_AW'(r_cnt - LEVEL_W'(1));
    assign w_cnt_next = r_cnt + LEVEL_W'(w_srl_push) - LEVEL_W'(w_srl_pop);

    srl_fifo_srl #(
        .WIDTH (WIDTH)
    ) u_srl (
        .i_clk  (CLK),
        .i_ce   (w_srl_push),
        .i_addr (w_addr),
        .i_data (S_DATA),
        .o_data (w_tap)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (w_push && !M_READY) begin
                    w_state_next = ST_RUN;
                end else if (!w_push && M_READY) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_RUN: begin
                if (w_cnt_next == '0) begin
                    w_state_next = ST_OUT;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state  <= ST_EMPTY;
            r_cnt    <= '0;
            r_m_data <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_load_out) begin
                r_m_data <= w_bypass ? S_DATA : w_tap;
            end
        end
    end

    assign w_level = r_cnt + LEVEL_W'(w_m_valid);

    assign M_DATA  = r_m_data;
    assign M_VALID = w_m_valid;
    assign LEVEL   = (w_level > LEVEL_MAX) ? LEVEL_MAX : w_level;
    assign AFULL   = (LEVEL >= AFULL_THR);

endmodule
